// File: rtl/ahb_slave_ctrl.sv
// Data-phase sequencer for the byte-wide AHB-Lite register slave: captures the
// address phase, inserts wait states, and drives strobes, HREADYOUT and HRESP.
module ahb_slave_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel_x,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  output logic              hreadyout,
  output logic              hresp,
  output logic [1:0]        read_select,
  output logic              rd_en,
  output logic              wr_en,
  output logic [1:0]        wr_sel
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned IDX_W = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT);

  generate
    if (RD_WAIT > 7 || WR_WAIT > 7) begin : g_bad_wait
      $error("ahb_slave_ctrl: RD_WAIT/WR_WAIT must be in 0..7");
    end
    if (ADDR_W < 3) begin : g_bad_addr
      $error("ahb_slave_ctrl: ADDR_W must be at least 3");
    end
  endgenerate

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] cap_idx, cap_idx_nx;
  logic             cap_wr, cap_wr_nx;

  logic             hreadyout_nx, hresp_nx, rd_en_nx, wr_en_nx;
  logic [IDX_W-1:0] read_select_nx, wr_sel_nx;

  logic             accept_c, err_c;
  logic [CNT_W-1:0] ld_cnt_c;
  logic             unused_htrans;

  assign unused_htrans = htrans[0];

  // Address-phase qualification and error decode
  assign accept_c = hsel_x & hready & htrans[1];
  assign err_c    = (hsize != 3'd0)
                  | (haddr[ADDR_W-1:2] != '0)
                  | (hwrite & ((haddr[1:0] == 2'd0) | (haddr[1:0] == 2'd3)));
  assign ld_cnt_c = hwrite ? WR_CNT : RD_CNT;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cap_idx     <= '0;
      cap_wr      <= 1'b0;
      hreadyout   <= 1'b1;
      hresp       <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      read_select <= '0;
      wr_sel      <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      cap_idx     <= cap_idx_nx;
      cap_wr      <= cap_wr_nx;
      hreadyout   <= hreadyout_nx;
      hresp       <= hresp_nx;
      rd_en       <= rd_en_nx;
      wr_en       <= wr_en_nx;
      read_select <= read_select_nx;
      wr_sel      <= wr_sel_nx;
    end
  end

  // Next state; IDLE, DONE and ERR2 all accept a new (possibly pipelined) transfer
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cap_idx_nx = cap_idx;
    cap_wr_nx  = cap_wr;
    case (state)
      ST_WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_DONE;
        end
      end
      ST_ERR1: begin
        state_nx = ST_ERR2;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        if (accept_c) begin
          cap_idx_nx = haddr[1:0];
          cap_wr_nx  = hwrite;
          if (err_c) begin
            state_nx = ST_ERR1;
          end else if (ld_cnt_c != '0) begin
            state_nx = ST_WAIT;
            cnt_nx   = ld_cnt_c;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe
  always_comb begin
    hreadyout_nx   = !((state_nx == ST_WAIT) || (state_nx == ST_ERR1));
    hresp_nx       = (state_nx == ST_ERR1) || (state_nx == ST_ERR2);
    rd_en_nx       = (state_nx == ST_DONE) && !cap_wr_nx;
    wr_en_nx       = (state_nx == ST_DONE) && cap_wr_nx;
    read_select_nx = rd_en_nx ? cap_idx_nx : read_select;
    wr_sel_nx      = wr_en_nx ? cap_idx_nx : wr_sel;
  end

endmodule
